hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-002 SHALL have port i_reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port i_id_valid, input, 1, ID stage holds a valid instruction.
REQ-004 SHALL have ports i_id_rs1 and i_id_rs2, input, 5 each, ID source register indices.
REQ-005 SHALL have ports i_id_use_rs1 and i_id_use_rs2, input, 1 each, ID instruction reads that source.
REQ-006 SHALL have ports i_id_regwrite (1) and i_id_rd (5), input, ID instruction destination.
REQ-007 SHALL have port i_ex_redirect, input, 1, taken branch/jump resolved in EX.
REQ-008 SHALL have ports i_wb_valid (1), i_wb_regwrite (1) and i_wb_rd (5), input, WB retirement.
REQ-009 SHALL have port o_stall, output, 1, hold PC and IF/ID; drives ID/EX i_stall=0 and bubble.
REQ-010 SHALL have port o_flush_if_id, output, 1, clear IF/ID valid.
REQ-011 SHALL have port o_flush_id_ex, output, 1, drives ID/EX i_flush.
REQ-012 SHALL have port o_busy_mask, output, 32, bit n = 1 when count[n] != 0.
REQ-013 SHALL have port o_stall_cycles, output, 16, saturating count of stalled cycles.
REQ-014 SHALL have port o_err, output, 1, sticky counter overflow/underflow flag.

Function
REQ-015 SHALL hold one 2-bit in-flight write counter count[n] per register n=1..31; count[0] is constant 0.
REQ-016 SHALL define hazard = i_id_valid & ((use_rs1 & rs1!=0 & count[rs1]!=0) | (use_rs2 & rs2!=0 & count[rs2]!=0)), evaluated combinationally from registered counts.
REQ-017 SHALL drive o_stall = hazard & ~i_ex_redirect; redirect has priority over stall.
REQ-018 SHALL drive o_flush_if_id = i_ex_redirect.
REQ-019 SHALL drive o_flush_id_ex = o_stall | i_ex_redirect.
REQ-020 SHALL define issue = i_id_valid & ~o_stall & ~i_ex_redirect & i_id_regwrite & i_id_rd!=0; issue increments count[i_id_rd] at the next edge.
REQ-021 SHALL define retire = i_wb_valid & i_wb_regwrite & i_wb_rd!=0; retire decrements count[i_wb_rd] at the next edge.
REQ-022 SHALL leave count unchanged when issue and retire target the same rd in the same cycle.
REQ-023 SHALL NOT bypass a same-cycle retire: the stall holds that cycle and releases the cycle after count reaches 0.
REQ-024 SHALL saturate count at 3 on issue when count=3 and set o_err.
REQ-025 SHALL hold count at 0 on retire when count=0 and set o_err.
REQ-026 SHALL keep o_err set until reset.
REQ-027 SHALL increment o_stall_cycles on every cycle o_stall=1 and saturate at 16'hFFFF.
REQ-028 SHALL contain no combinational path from i_wb_* to o_stall.

Reset
REQ-029 SHALL, on any edge with i_reset_n=0, clear all counts, o_err and o_stall_cycles, overriding issue and retire in that cycle.
REQ-030 SHALL, when reset is asserted mid-operation, start the first cycle after reset with o_busy_mask=0 and o_stall=0 for any ID inputs.

Verification
REQ-031 SHALL cover RAW stall: issue x5 write, then ID reads x5 -> o_stall=1 and o_flush_id_ex=1 each cycle until WB retires x5; o_stall=0 the cycle after retire; o_stall_cycles equals the stalled cycles.
REQ-032 SHALL cover x0: writer rd=0, reader rs1=0 -> no count change, o_stall=0, o_busy_mask=0.
REQ-033 SHALL cover redirect priority: hazard and i_ex_redirect=1 together -> o_stall=0, o_flush_if_id=1, o_flush_id_ex=1, and the ID writer to x7 does not increment count[7].
REQ-034 SHALL cover WAW with simultaneous events: two writers to x3 issued back-to-back -> count[3]=2; a retire of x3 in the same cycle as a third issue to x3 -> count[3] stays 2.
REQ-035 SHALL cover error flags: retire of x9 with count 0 -> o_err=1 and count stays 0; a fourth issue to x9 with count 3 -> o_err=1 and count stays 3; o_err stays 1 until reset.
REQ-036 SHALL cover mid-operation reset: reset with count[4]=2 and o_stall_cycles=10 -> all counts 0, o_stall_cycles=0, o_err=0 on the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register-file hazard scoreboard: one 2-bit in-flight write counter per GPR,
// producing stall/flush controls for IF/ID and ID/EX plus stall statistics.
module hazard_scoreboard (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_id_valid,
   input  logic [4:0]  i_id_rs1,
   input  logic [4:0]  i_id_rs2,
   input  logic        i_id_use_rs1,
   input  logic        i_id_use_rs2,
   input  logic        i_id_regwrite,
   input  logic [4:0]  i_id_rd,
   input  logic        i_ex_redirect,
   input  logic        i_wb_valid,
   input  logic        i_wb_regwrite,
   input  logic [4:0]  i_wb_rd,
   output logic        o_stall,
   output logic        o_flush_if_id,
   output logic        o_flush_id_ex,
   output logic [31:0] o_busy_mask,
   output logic [15:0] o_stall_cycles,
   output logic        o_err
);

   logic [31:0][1:0] r_count;
   logic [31:0][1:0] w_count_nxt;
   logic [15:0]      r_stall_cycles;
   logic             r_err;
   logic [31:0]      w_busy;
   logic [31:0]      w_inc_vec;
   logic [31:0]      w_dec_vec;
   logic             w_hazard;
   logic             w_stall;
   logic             w_issue;
   logic             w_retire;
   logic             w_err_set;

   // Busy decode from registered counts only, so WB inputs never reach o_stall.
   always_comb begin
      w_busy = 32'd0;
      for (int n = 1; n < 32; n++) begin
         w_busy[n] = (r_count[n] != 2'd0);
      end
   end

   assign w_hazard = i_id_valid &
                     ((i_id_use_rs1 & w_busy[i_id_rs1]) |
                      (i_id_use_rs2 & w_busy[i_id_rs2]));
   assign w_stall  = w_hazard & ~i_ex_redirect;
   assign w_issue  = i_id_valid & ~w_stall & ~i_ex_redirect & i_id_regwrite &
                     (i_id_rd != 5'd0);
   assign w_retire = i_wb_valid & i_wb_regwrite & (i_wb_rd != 5'd0);

   assign w_inc_vec = {31'd0, w_issue}  << i_id_rd;
   assign w_dec_vec = {31'd0, w_retire} << i_wb_rd;

   // Per-register next count; simultaneous issue+retire to one rd cancels out.
   always_comb begin
      w_count_nxt = r_count;
      w_err_set   = 1'b0;
      for (int n = 1; n < 32; n++) begin
         case ({w_inc_vec[n], w_dec_vec[n]})
            2'b10: begin
               if (r_count[n] == 2'd3) begin
                  w_err_set = 1'b1;
               end else begin
                  w_count_nxt[n] = r_count[n] + 2'd1;
               end
            end
            2'b01: begin
               if (r_count[n] == 2'd0) begin
                  w_err_set = 1'b1;
               end else begin
                  w_count_nxt[n] = r_count[n] - 2'd1;
               end
            end
            default: w_count_nxt[n] = r_count[n];
         endcase
      end
      w_count_nxt[0] = 2'd0;
   end

   // State update; reset overrides any issue/retire in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_count        <= '0;
         r_err          <= 1'b0;
         r_stall_cycles <= 16'd0;
      end else begin
         r_count <= w_count_nxt;
         r_err   <= r_err | w_err_set;
         if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
         end else begin
            r_stall_cycles <= r_stall_cycles;
         end
      end
   end

   assign o_stall        = w_stall;
   assign o_flush_if_id  = i_ex_redirect;
   assign o_flush_id_ex  = w_stall | i_ex_redirect;
   assign o_busy_mask    = w_busy;
   assign o_stall_cycles = r_stall_cycles;
   assign o_err          = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard: one task per scenario, inline checks.
module tb_hazard_scoreboard;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_id_valid;
   logic [4:0]  i_id_rs1;
   logic [4:0]  i_id_rs2;
   logic        i_id_use_rs1;
   logic        i_id_use_rs2;
   logic        i_id_regwrite;
   logic [4:0]  i_id_rd;
   logic        i_ex_redirect;
   logic        i_wb_valid;
   logic        i_wb_regwrite;
   logic [4:0]  i_wb_rd;
   logic        o_stall;
   logic        o_flush_if_id;
   logic        o_flush_id_ex;
   logic [31:0] o_busy_mask;
   logic [15:0] o_stall_cycles;
   logic        o_err;

   int errors = 0;
   int checks = 0;

   hazard_scoreboard dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_id_valid(i_id_valid),
      .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
      .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
      .i_id_regwrite(i_id_regwrite), .i_id_rd(i_id_rd),
      .i_ex_redirect(i_ex_redirect), .i_wb_valid(i_wb_valid),
      .i_wb_regwrite(i_wb_regwrite), .i_wb_rd(i_wb_rd),
      .o_stall(o_stall), .o_flush_if_id(o_flush_if_id),
      .o_flush_id_ex(o_flush_id_ex), .o_busy_mask(o_busy_mask),
      .o_stall_cycles(o_stall_cycles), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_id_valid = 1'b0; i_id_rs1 = 5'd0; i_id_rs2 = 5'd0;
      i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0;
      i_id_regwrite = 1'b0; i_id_rd = 5'd0; i_ex_redirect = 1'b0;
      i_wb_valid = 1'b0; i_wb_regwrite = 1'b0; i_wb_rd = 5'd0;
      #1;
   endtask

   task automatic id_write(input logic [4:0] rd);
      idle();
      i_id_valid = 1'b1; i_id_regwrite = 1'b1; i_id_rd = rd;
      #1;
   endtask

   task automatic wb_retire(input logic [4:0] rd);
      idle();
      i_wb_valid = 1'b1; i_wb_regwrite = 1'b1; i_wb_rd = rd;
      #1;
   endtask

   task automatic do_reset();
      idle();
      i_reset_n = 1'b0;
      tick();
      i_reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected %h", o_busy_mask, 32'd0); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
      checks++; if (o_stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", o_stall_cycles); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
   endtask

   task automatic test_raw();
      id_write(5'd5);
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy: got %h expected %h", o_busy_mask, 32'h20); end
      i_id_valid = 1'b1; i_id_use_rs1 = 1'b1; i_id_rs1 = 5'd5;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c%0d: got %b expected 1", c, o_stall); end
         checks++; if (o_flush_id_ex !== 1'b1) begin errors++; $display("FAIL raw_flush_c%0d: got %b expected 1", c, o_flush_id_ex); end
         tick();
      end
      i_wb_valid = 1'b1; i_wb_regwrite = 1'b1; i_wb_rd = 5'd5;
      #1;
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %b expected 1", o_stall); end
      tick();
      i_wb_valid = 1'b0; i_wb_regwrite = 1'b0; i_wb_rd = 5'd0;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %b expected 0", o_stall); end
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL raw_busy_clear: got %h expected 0", o_busy_mask); end
      checks++; if (o_stall_cycles !== 16'd4) begin errors++; $display("FAIL raw_stall_cycles: got %0d expected 4", o_stall_cycles); end
      tick();
      idle();
   endtask

   task automatic test_x0();
      id_write(5'd0);
      i_id_use_rs1 = 1'b1; i_id_use_rs2 = 1'b1;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", o_stall); end
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL x0_busy: got %h expected 0", o_busy_mask); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL x0_err: got %b expected 0", o_err); end
   endtask

   task automatic test_redirect();
      id_write(5'd8);
      tick();
      id_write(5'd7);
      i_id_use_rs1 = 1'b1; i_id_rs1 = 5'd8; i_ex_redirect = 1'b1;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL redir_stall: got %b expected 0", o_stall); end
      checks++; if (o_flush_if_id !== 1'b1) begin errors++; $display("FAIL redir_flush_if_id: got %b expected 1", o_flush_if_id); end
      checks++; if (o_flush_id_ex !== 1'b1) begin errors++; $display("FAIL redir_flush_id_ex: got %b expected 1", o_flush_id_ex); end
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'h0000_0100) begin errors++; $display("FAIL redir_busy: got %h expected %h", o_busy_mask, 32'h100); end
      wb_retire(5'd8);
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL redir_cleanup: got %h expected 0", o_busy_mask); end
   endtask

   task automatic test_back_to_back();
      id_write(5'd3);
      tick();
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'h0000_0008) begin errors++; $display("FAIL waw_busy: got %h expected %h", o_busy_mask, 32'h8); end
      id_write(5'd3);
      i_wb_valid = 1'b1; i_wb_regwrite = 1'b1; i_wb_rd = 5'd3;
      #1;
      tick();
      wb_retire(5'd3);
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'h0000_0008) begin errors++; $display("FAIL waw_count_after_1: got %h expected %h", o_busy_mask, 32'h8); end
      wb_retire(5'd3);
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL waw_count_after_2: got %h expected 0", o_busy_mask); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL waw_err: got %b expected 0", o_err); end
   endtask

   task automatic test_errors();
      do_reset();
      wb_retire(5'd9);
      tick();
      idle();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b expected 1", o_err); end
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL underflow_busy: got %h expected 0", o_busy_mask); end
      do_reset();
      id_write(5'd9);
      tick(); tick(); tick();
      idle();
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL three_issue_err: got %b expected 0", o_err); end
      id_write(5'd9);
      tick();
      idle();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", o_err); end
      checks++; if (o_busy_mask !== 32'h0000_0200) begin errors++; $display("FAIL overflow_busy: got %h expected %h", o_busy_mask, 32'h200); end
      wb_retire(5'd9);
      tick(); tick();
      idle();
      checks++; if (o_busy_mask !== 32'h0000_0200) begin errors++; $display("FAIL sat_after_2_retire: got %h expected %h", o_busy_mask, 32'h200); end
      wb_retire(5'd9);
      tick();
      idle();
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL sat_after_3_retire: got %h expected 0", o_busy_mask); end
      tick(); tick();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", o_err); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      id_write(5'd4);
      tick(); tick();
      idle();
      i_id_valid = 1'b1; i_id_use_rs2 = 1'b1; i_id_rs2 = 5'd4;
      for (int c = 0; c < 10; c++) tick();
      checks++; if (o_stall_cycles !== 16'd10) begin errors++; $display("FAIL pre_reset_stall_cycles: got %0d expected 10", o_stall_cycles); end
      wb_retire(5'd11);
      tick();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL pre_reset_err: got %b expected 1", o_err); end
      i_id_valid = 1'b1; i_id_regwrite = 1'b1; i_id_rd = 5'd6;
      i_id_use_rs2 = 1'b1; i_id_rs2 = 5'd4;
      i_reset_n = 1'b0;
      #1;
      tick();
      i_reset_n = 1'b1;
      i_wb_valid = 1'b0; i_id_rd = 5'd0; i_id_regwrite = 1'b0;
      #1;
      checks++; if (o_busy_mask !== 32'd0) begin errors++; $display("FAIL midrst_busy: got %h expected 0", o_busy_mask); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", o_stall); end
      checks++; if (o_stall_cycles !== 16'd0) begin errors++; $display("FAIL midrst_stall_cycles: got %0d expected 0", o_stall_cycles); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", o_err); end
      idle();
   endtask

   initial begin
      i_reset_n = 1'b0;
      idle();
      tick();
      test_reset();
      test_raw();
      test_x0();
      test_redirect();
      test_back_to_back();
      test_errors();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
